mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
Initiator side of the byte-wide data-memory port. It sits in the MEM stage of the pipeline and turns one RISC-V load or store (lb/lh/lw/lbu/lhu/sb/sh/sw) into a sequence of single-byte memory transactions. The byte order is little-endian, and the memory answers on a ready/valid byte interface. While a request is in flight, the block stalls the pipeline. When the request finishes, it returns sign- or zero-extended load data, or an error flag.

Parameters:
ADDR_W, 32, byte-address width of the request and memory ports.
DATA_W, 32, request data width; must be 32.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  asynchronous active-low reset (0 = reset).
req_valid  in  1  MEM stage presents a request.
req_write  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 field of the load/store instruction.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data.
req_ready  out  1  block is idle and accepts a request.
busy  out  1  pipeline stall; equals ~req_ready.
resp_valid  out  1  single-cycle completion pulse.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  1  request was misaligned or illegal; qualified by resp_valid.
mem_en  out  1  byte transaction request.
mem_we  out  1  byte write.
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  8  write byte.
mem_rdata  in  8  read byte, valid when mem_en & mem_ready.
mem_ready  in  1  memory completes the current byte this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, byte counter=0, every latched field=0, resp_rdata=0.
  - Outputs after reset: req_ready=1, busy=0, resp_valid=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset during an access aborts it. Bytes already written stay in memory; there is no rollback.
- FSM states:
  - IDLE: req_ready=1. A rising edge with req_valid=1 accepts the request and latches write, funct3, addr and wdata.
  - Legality is checked at acceptance:
    - Loads allow funct3 000/001/010/100/101. Stores allow 000/001/010. Anything else is illegal.
    - Byte count n is 1 (x00), 2 (x01) or 4 (010).
    - A halfword with addr[0]=1 is misaligned. A word with addr[1:0]!=00 is misaligned.
  - A legal request goes to ACCESS with counter k=0. An illegal or misaligned request goes directly to DONE with err=1.
  - ACCESS: drive mem_en=1, mem_we=write, mem_addr=addr+k (modulo 2^ADDR_W), mem_wdata=wdata[8k+7:8k].
    - Outputs hold steady while mem_ready=0; there is no timeout.
    - On mem_ready=1: a load captures mem_rdata into byte lane k. Then k increments. If k==n-1, the next state is DONE.
  - DONE: resp_valid=1 for exactly one cycle.
    - resp_rdata is the extended value: lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
    - resp_err is as latched.
    - Next state is IDLE.
- mem_* outputs are 0 in IDLE and DONE.
- resp_rdata is registered and holds its value until the next DONE.
- req_valid is ignored outside IDLE. The requester holds the request until it sees resp_valid.
- Latency with mem_ready tied 1:
  - Request accepted at edge 0, then n ACCESS cycles, then resp_valid in cycle n+1.
  - lw = 5 cycles, lh = 3, lb = 2. Error responses appear in cycle 1.
- Each wait cycle (mem_ready=0) adds one cycle.

Decomposition:
- Shared package mem_seq_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state enum IDLE/ACCESS/DONE;
  - a function that computes the byte count.
- One combinational sub-module, load_extend (funct3 + raw 32-bit assembled data -> extended result), is natural. It is reusable by a future cache path.

Test Plan:
- lw at 0x10, memory bytes 0x10..0x13 = 78 56 34 12, mem_ready=1 -> mem_addr steps 0x10..0x13 in cycles 1-4; resp_valid in cycle 5 with resp_rdata=0x12345678, resp_err=0.
- lb at 0x03 with byte 0x80 -> resp_rdata=0xFFFFFF80 in cycle 2. lbu at the same address -> 0x00000080.
- sh at 0x20, wdata=0xAABBCCDD -> writes DD@0x20 then CC@0x21 with mem_we=1; resp_valid in cycle 3 with resp_rdata=0. Bytes 0x22/0x23 are untouched.
- lw at 0x02 (misaligned), and separately sb with funct3=100 -> mem_en never asserts; resp_valid=1, resp_err=1 in cycle 1.
- lw at 0x40 with mem_ready=0 for 2 cycles during byte 1 -> mem_addr holds 0x41 for 3 cycles; resp_valid in cycle 7 with correct data.
- rst=0 asynchronously after 2 bytes of an sw -> immediately req_ready=1, mem_en=0, resp_valid never pulses. Bytes 0,1 are written and bytes 2,3 are not. A new lw after reset completes normally.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: funct3 codes, FSM states,
// and the byte-count and legality helpers used when a request is accepted.
package mem_seq_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Bytes moved for a funct3; only meaningful once the request is known to be legal.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic req_legal(input logic write, input logic [2:0] f3, input logic [1:0] a);
    logic op_ok;
    logic aligned;
    if (write) op_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       op_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b01:   aligned = (a[0] == 1'b0);
      2'b10:   aligned = (a == 2'b00);
      default: aligned = 1'b1;
    endcase
    return op_ok && aligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extension: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
// Purely combinational; no backpressure.
module load_extend
  import mem_seq_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   ext_o = {24'd0, raw_i[7:0]};
      F3_HU:   ext_o = {16'd0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: splits one load/store into little-endian byte transactions.
// Latency n+1 cycles plus one per mem_ready=0 cycle; stalls the pipe (busy) until resp_valid.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  state_e              state_q;
  logic [1:0]          k_q;
  logic                write_q;
  logic [2:0]          funct3_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;

  logic [DATA_W-1:0]   assembled_d;
  logic [DATA_W-1:0]   extended_d;
  logic [1:0]          k_d;
  logic [7:0]          next_wbyte_d;
  logic                last_byte;

  // The byte arriving this cycle is merged in before extension so DONE has the full value.
  always_comb begin
    assembled_d = rbuf_q;
    assembled_d[{k_q, 3'b000} +: 8] = mem_rdata;
  end

  assign k_d          = k_q + 2'd1;
  assign next_wbyte_d = wdata_q[{k_d, 3'b000} +: 8];
  assign last_byte    = ({1'b0, k_q} == (byte_count(funct3_q) - 3'd1));

  load_extend u_load_extend (
    .funct3_i (funct3_q),
    .raw_i    (assembled_d),
    .ext_o    (extended_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            funct3_q    <= req_funct3;
            wdata_q     <= req_wdata;
            k_q         <= 2'd0;
            rbuf_q      <= '0;
            req_ready_q <= 1'b0;
            if (req_legal(req_write, req_funct3, req_addr[1:0])) begin
              state_q     <= ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= req_write;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata[7:0];
            end else begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rbuf_q <= assembled_d;
            k_q    <= k_d;
            if (last_byte) begin
              state_q      <= DONE;
              mem_en_q     <= 1'b0;
              mem_we_q     <= 1'b0;
              mem_addr_q   <= '0;
              mem_wdata_q  <= 8'd0;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= write_q ? '0 : extended_d;
            end else begin
              mem_addr_q  <= mem_addr_q + ADDR_W'(1);
              mem_wdata_q <= next_wbyte_d;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = ~req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed vector table, multi-cycle corner sequences,
// and random transactions against a byte-array memory reference model.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  logic [7:0]  mem       [256];
  logic [7:0]  model_mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cnt41    = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk)
    if (mem_en && mem_we && mem_ready) mem[mem_addr[7:0]] <= mem_wdata;

  always @(negedge clk)
    if (mem_en && mem_addr == 32'h41) cnt41++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] b);
    mem[a] = b;
    model_mem[a] = b;
  endtask

  // Reference rules, expressed as plain arithmetic on the funct3 value and address.
  function automatic int ref_bytes(input logic [2:0] f3);
    int low;
    low = int'(f3) % 4;
    return (low == 0) ? 1 : (low == 1) ? 2 : 4;
  endfunction

  function automatic bit ref_ok(input logic w, input logic [2:0] f3, input logic [31:0] a);
    bit op_ok;
    if (w) op_ok = (f3 <= 2);
    else   op_ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
    return op_ok && ((a % ref_bytes(f3)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < ref_bytes(f3); i++)
      v = v + (32'(model_mem[(a + i) % 256]) << (8 * i));
    if (f3 == 0 && v >= 128)   v = v + 32'hFFFFFF00;
    if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit rnd, input int stall_byte,
                        input int stall_len, output logic [31:0] got_rdata,
                        output logic got_err, output int got_cyc);
    bit          legal;
    int          n, cyc, waits, done_b, stalled, busy_bad, bad;
    bit          seen;
    logic [31:0] exp_rdata;
    logic [31:0] addrs[$];
    n         = ref_bytes(f3);
    legal     = ref_ok(w, f3, a);
    exp_rdata = (legal && !w) ? ref_load(f3, a) : 32'h0;
    got_rdata = 'x;
    got_err   = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc = 0; seen = 0; waits = 0; done_b = 0; stalled = 0; busy_bad = 0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (busy !== ~req_ready) busy_bad++;
      if (resp_valid) begin
        seen = 1;
        got_rdata = resp_rdata;
        got_err = resp_err;
        req_valid = 1'b0;
        chk("mem_en_in_done", {31'd0, mem_en}, 32'd0);
      end else if (mem_en) begin
        if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
        else if (done_b == stall_byte && stalled < stall_len) begin
          mem_ready = 1'b0;
          stalled++;
        end else mem_ready = 1'b1;
        if (mem_ready) begin
          addrs.push_back(mem_addr);
          done_b++;
        end else waits++;
      end
    end
    req_valid = 1'b0;
    got_cyc = cyc;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid in %0d cycles, required one", cyc);
    end else begin
      chk("latency", cyc, legal ? n + 1 + waits : 1);
      chk("resp_err", {31'd0, got_err}, {31'd0, !legal});
      chk("resp_rdata", got_rdata, exp_rdata);
    end
    bad = 0;
    if (addrs.size() != (legal ? n : 0)) bad++;
    else foreach (addrs[i]) if (addrs[i] !== a + i) bad++;
    chk("addr_seq", bad, 0);
    if (legal && w)
      for (int i = 0; i < n; i++) model_mem[(a + i) % 256] = 8'((wd >> (8 * i)) & 32'hFF);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
    chk("mem_image", bad, 0);
    chk("busy_eq_not_ready", busy_bad, 0);
    @(posedge clk); #1;
    chk("resp_pulse_single", {31'd0, resp_valid}, 32'd0);
    chk("rdata_hold", resp_rdata, exp_rdata);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    mem_ready = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] r;
    logic        e;
    int          c, pulses;
    logic [2:0]  legal_f3 [5];
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b1;
    for (int i = 0; i < 256; i++) poke(i, 8'($urandom));
    poke(32'h10, 8'h78); poke(32'h11, 8'h56); poke(32'h12, 8'h34); poke(32'h13, 8'h12);
    poke(32'h03, 8'h80);
    poke(32'h20, 8'h11); poke(32'h21, 8'h22); poke(32'h22, 8'h33); poke(32'h23, 8'h44);
    poke(32'h40, 8'hEF); poke(32'h41, 8'hCD); poke(32'h42, 8'hAB); poke(32'h43, 8'h89);
    for (int i = 32'h60; i < 32'h64; i++) poke(i, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h12345678, 1'b0, 5};
    vecs[1]  = '{1'b0, 3'b000, 32'h03, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    vecs[2]  = '{1'b0, 3'b100, 32'h03, 32'h0,        32'h00000080, 1'b0, 2};
    vecs[3]  = '{1'b1, 3'b001, 32'h20, 32'hAABBCCDD, 32'h0,        1'b0, 3};
    vecs[4]  = '{1'b0, 3'b010, 32'h02, 32'h0,        32'h0,        1'b1, 1};
    vecs[5]  = '{1'b1, 3'b100, 32'h04, 32'h5A,       32'h0,        1'b1, 1};
    vecs[6]  = '{1'b0, 3'b001, 32'h10, 32'h0,        32'h00005678, 1'b0, 3};
    vecs[7]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00001234, 1'b0, 3};
    vecs[8]  = '{1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1};
    vecs[10] = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h00000012, 1'b0, 2};
    vecs[11] = '{1'b1, 3'b010, 32'h30, 32'h01020304, 32'h0,        1'b0, 5};

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0, -1, 0, r, e, c);
      chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_cycles", i), c, vecs[i].exp_cyc);
      if (i == 3) begin
        chk("sh_byte20", {24'd0, mem[32'h20]}, 32'hDD);
        chk("sh_byte21", {24'd0, mem[32'h21]}, 32'hCC);
        chk("sh_byte22_untouched", {24'd0, mem[32'h22]}, 32'h33);
        chk("sh_byte23_untouched", {24'd0, mem[32'h23]}, 32'h44);
      end
    end

    // Two wait cycles on byte 1 of a word load.
    cnt41 = 0;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1, 2, r, e, c);
    chk("stall_rdata", r, 32'h89ABCDEF);
    chk("stall_cycles", c, 7);
    chk("stall_addr41_hold", cnt41, 3);

    // Asynchronous reset after two bytes of a word store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h60; req_wdata = 32'hDEADBEEF; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_addr", mem_addr, 32'h62);
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) pulses++; end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (resp_valid) pulses++; end
    chk("rst_mid_no_resp", pulses, 0);
    chk("rst_mid_byte0", {24'd0, mem[32'h60]}, 32'hEF);
    chk("rst_mid_byte1", {24'd0, mem[32'h61]}, 32'hBE);
    chk("rst_mid_byte2", {24'd0, mem[32'h62]}, 32'h00);
    chk("rst_mid_byte3", {24'd0, mem[32'h63]}, 32'h00);
    model_mem[32'h60] = 8'hEF;
    model_mem[32'h61] = 8'hBE;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, -1, 0, r, e, c);
    chk("post_rst_lw", r, 32'h12345678);

    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 251));
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom, 1'b1, -1, 0, r, e, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
